// File: rtl/johnson_stepper_ctrl.sv
// johnson_stepper_ctrl
// Stepper-phase sequencer around a 2N-state Johnson counter. A move command
// (step count, direction, step period) is taken over a valid/ready handshake
// and the Johnson state advances one position per step at the programmed
// rate. Gives done/aborted pulses and a tracked phase index.
// Optional feature macro: JSTEP_IDLE_OFF_EN (count driven to zero while
// idle; the internal Johnson state and phase index are kept).

module johnson_stepper_ctrl #(
  parameter int N    = 4,
  parameter int CNTW = 16,
  parameter int DIVW = 16,
  localparam int PW  = $clog2(2 * N)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CNTW-1:0] cmd_steps,
  input  logic            cmd_dir,
  input  logic [DIVW-1:0] cmd_div,
  input  logic            abort,
  output logic [N-1:0]    count,
  output logic [PW-1:0]   phase_idx,
  output logic [CNTW-1:0] steps_left,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  localparam logic [PW-1:0] PH_LAST = PW'(2 * N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_john;
  logic [PW-1:0]   r_phase;
  logic [CNTW-1:0] r_steps_left;
  logic [DIVW-1:0] r_div;
  logic [DIVW-1:0] r_presc;
  logic            r_dir;
  logic            r_busy;
  logic            r_done;
  logic            r_aborted;
  logic            r_cmd_ready;

  logic [N-1:0]    w_john_next;
  logic [PW-1:0]   w_phase_next;
  logic            w_accept;
  logic            w_step;
  logic            w_last_step;
  logic            w_run_next;

  // Next Johnson state / phase for one step in the latched direction, and
  // the handshake, step and next-state qualifiers.
  always_comb begin
    w_john_next  = r_john;
    w_phase_next = r_phase;
    if (r_dir == 1'b0) begin
      w_john_next  = {r_john[N-2:0], ~r_john[N-1]};
      w_phase_next = (r_phase == PH_LAST) ? {PW{1'b0}} : (r_phase + PW'(1));
    end else begin
      w_john_next  = {~r_john[0], r_john[N-1:1]};
      w_phase_next = (r_phase == {PW{1'b0}}) ? PH_LAST : (r_phase - PW'(1));
    end
    w_accept    = (r_state == S_IDLE) && cmd_valid;
    // Abort wins over a coincident step: no step is taken on that edge.
    w_step      = (r_state == S_RUN) && (r_presc == {DIVW{1'b0}}) && !abort;
    w_last_step = w_step && (r_steps_left == CNTW'(1));
    if (r_state == S_IDLE) begin
      w_run_next = w_accept && (cmd_steps != {CNTW{1'b0}});
    end else begin
      w_run_next = !abort && !w_last_step;
    end
  end

  // Move sequencer: command accept, prescaled stepping, completion and abort.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= S_IDLE;
      r_john       <= {N{1'b0}};
      r_phase      <= {PW{1'b0}};
      r_steps_left <= {CNTW{1'b0}};
      r_div        <= {DIVW{1'b0}};
      r_presc      <= {DIVW{1'b0}};
      r_dir        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir        <= cmd_dir;
            r_div        <= cmd_div;
            r_presc      <= cmd_div;
            r_steps_left <= cmd_steps;
            if (cmd_steps == {CNTW{1'b0}}) begin
              // Zero-length move completes at once without touching position.
              r_done <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state      <= S_IDLE;
            r_aborted    <= 1'b1;
            r_steps_left <= {CNTW{1'b0}};
            r_busy       <= 1'b0;
            r_cmd_ready  <= 1'b1;
          end else if (w_step) begin
            r_john       <= w_john_next;
            r_phase      <= w_phase_next;
            r_presc      <= r_div;
            r_steps_left <= r_steps_left - CNTW'(1);
            if (w_last_step) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end else begin
            r_presc <= r_presc - DIVW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef JSTEP_IDLE_OFF_EN
  logic [N-1:0] r_count_out;

  // Coil-drive image: zero whenever the next state is idle, otherwise the
  // Johnson state the counter will hold after this edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_count_out <= {N{1'b0}};
    end else if (w_run_next) begin
      r_count_out <= w_step ? w_john_next : r_john;
    end else begin
      r_count_out <= {N{1'b0}};
    end
  end

  assign count = r_count_out;
`else
  logic w_unused_run_next;
  assign w_unused_run_next = w_run_next;
  assign count = r_john;
`endif

  assign phase_idx  = r_phase;
  assign steps_left = r_steps_left;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign cmd_ready  = r_cmd_ready;

endmodule

// File: tb/tb_johnson_stepper_ctrl.sv
// Directed bench for johnson_stepper_ctrl (N=4, default build).
module tb_johnson_stepper_ctrl;

  localparam int N    = 4;
  localparam int CNTW = 16;
  localparam int DIVW = 16;
  localparam int PW   = 3;

  logic            clk;
  logic            arst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CNTW-1:0] cmd_steps;
  logic            cmd_dir;
  logic [DIVW-1:0] cmd_div;
  logic            abort;
  logic [N-1:0]    count;
  logic [PW-1:0]   phase_idx;
  logic [CNTW-1:0] steps_left;
  logic            busy;
  logic            done;
  logic            aborted;

  int n_cmp;
  int n_err;

  logic [3:0] fwd_seq [5];
  logic [3:0] rev_seq [6];
  logic [2:0] rev_ph  [6];
  logic [3:0] prev_cnt;

  johnson_stepper_ctrl #(.N(N), .CNTW(CNTW), .DIVW(DIVW)) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_div    (cmd_div),
    .abort      (abort),
    .count      (count),
    .phase_idx  (phase_idx),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    fwd_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
    rev_seq = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    rev_ph  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    arst = 1'b1; cmd_valid = 1'b0; cmd_steps = 16'd0; cmd_dir = 1'b0;
    cmd_div = 16'd0; abort = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_phase", 32'(phase_idx), 32'd0);
    chk("rst_steps", 32'(steps_left), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    #10 arst = 1'b0;
    step_clk();

    // Move 1: 5 steps forward, div 0
    cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_dir = 1'b0; cmd_div = 16'd0;
    step_clk();
    cmd_valid = 1'b0;
    chk("m1_acc_busy", 32'(busy), 32'd1);
    chk("m1_acc_ready", 32'(cmd_ready), 32'd0);
    chk("m1_acc_steps", 32'(steps_left), 32'd5);
    chk("m1_acc_count", 32'(count), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step_clk();
      chk("m1_count", 32'(count), 32'(fwd_seq[i-1]));
      chk("m1_phase", 32'(phase_idx), 32'(i));
      chk("m1_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
      chk("m1_busy", 32'(busy), (i == 5) ? 32'd0 : 32'd1);
    end
    chk("m1_ready", 32'(cmd_ready), 32'd1);
    step_clk();
    chk("m1_done_drop", 32'(done), 32'd0);

    // Move 2: 6 steps reverse, div 2
    cmd_valid = 1'b1; cmd_steps = 16'd6; cmd_dir = 1'b1; cmd_div = 16'd2;
    step_clk();
    cmd_valid = 1'b0;
    chk("m2_acc_busy", 32'(busy), 32'd1);
    prev_cnt = 4'b1110;
    for (int j = 0; j < 6; j++) begin
      step_clk();
      chk("m2_hold", 32'(count), 32'(prev_cnt));
      step_clk();
      step_clk();
      chk("m2_count", 32'(count), 32'(rev_seq[j]));
      chk("m2_phase", 32'(phase_idx), 32'(rev_ph[j]));
      chk("m2_done", 32'(done), (j == 5) ? 32'd1 : 32'd0);
      prev_cnt = rev_seq[j];
    end
    chk("m2_steps", 32'(steps_left), 32'd0);
    step_clk();

    // Move 3: zero steps
    cmd_valid = 1'b1; cmd_steps = 16'd0; cmd_dir = 1'b0; cmd_div = 16'd7;
    step_clk();
    cmd_valid = 1'b0;
    chk("m3_done", 32'(done), 32'd1);
    chk("m3_busy", 32'(busy), 32'd0);
    chk("m3_ready", 32'(cmd_ready), 32'd1);
    chk("m3_count", 32'(count), 32'b1000);
    chk("m3_phase", 32'(phase_idx), 32'd7);
    step_clk();
    chk("m3_done_drop", 32'(done), 32'd0);
    chk("m3_busy2", 32'(busy), 32'd0);

    // Abort while idle is ignored
    abort = 1'b1;
    step_clk();
    chk("idle_abort_aborted", 32'(aborted), 32'd0);
    chk("idle_abort_ready", 32'(cmd_ready), 32'd1);
    abort = 1'b0;

    // Move 4: 10 steps fwd div 3, abort coincident with third step
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = 1'b0; cmd_div = 16'd3;
    step_clk();
    cmd_valid = 1'b0;
    repeat (4) step_clk();
    chk("m4_s1_count", 32'(count), 32'b0000);
    chk("m4_s1_phase", 32'(phase_idx), 32'd0);
    repeat (4) step_clk();
    chk("m4_s2_count", 32'(count), 32'b0001);
    chk("m4_s2_steps", 32'(steps_left), 32'd8);
    repeat (3) step_clk();
    abort = 1'b1;
    step_clk();
    chk("m4_aborted", 32'(aborted), 32'd1);
    chk("m4_done", 32'(done), 32'd0);
    chk("m4_steps", 32'(steps_left), 32'd0);
    chk("m4_count", 32'(count), 32'b0001);
    chk("m4_phase", 32'(phase_idx), 32'd1);
    chk("m4_busy", 32'(busy), 32'd0);
    chk("m4_ready", 32'(cmd_ready), 32'd1);
    abort = 1'b0;
    step_clk();
    chk("m4_aborted_drop", 32'(aborted), 32'd0);

    // Move 5: held command while busy, accepted on the done cycle
    cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_dir = 1'b0; cmd_div = 16'd1;
    step_clk();
    cmd_steps = 16'd1; cmd_dir = 1'b1; cmd_div = 16'd0;
    step_clk();
    chk("m5_e1_ready", 32'(cmd_ready), 32'd0);
    chk("m5_e1_count", 32'(count), 32'b0001);
    step_clk();
    chk("m5_e2_count", 32'(count), 32'b0011);
    chk("m5_e2_steps", 32'(steps_left), 32'd1);
    step_clk();
    step_clk();
    chk("m5_e4_count", 32'(count), 32'b0111);
    chk("m5_e4_phase", 32'(phase_idx), 32'd3);
    chk("m5_e4_done", 32'(done), 32'd1);
    chk("m5_e4_ready", 32'(cmd_ready), 32'd1);
    step_clk();
    cmd_valid = 1'b0;
    chk("m5_e5_busy", 32'(busy), 32'd1);
    chk("m5_e5_ready", 32'(cmd_ready), 32'd0);
    chk("m5_e5_steps", 32'(steps_left), 32'd1);
    chk("m5_e5_count", 32'(count), 32'b0111);
    step_clk();
    chk("m5_e6_count", 32'(count), 32'b0011);
    chk("m5_e6_phase", 32'(phase_idx), 32'd2);
    chk("m5_e6_done", 32'(done), 32'd1);
    chk("m5_e6_busy", 32'(busy), 32'd0);

    // Move 6: asynchronous reset mid-move
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b0; cmd_div = 16'd5;
    step_clk();
    cmd_valid = 1'b0;
    repeat (6) step_clk();
    chk("m6_count", 32'(count), 32'b0111);
    chk("m6_phase", 32'(phase_idx), 32'd3);
    #2 arst = 1'b1;
    #1;
    chk("m6_rst_count", 32'(count), 32'd0);
    chk("m6_rst_phase", 32'(phase_idx), 32'd0);
    chk("m6_rst_busy", 32'(busy), 32'd0);
    chk("m6_rst_ready", 32'(cmd_ready), 32'd1);
    chk("m6_rst_steps", 32'(steps_left), 32'd0);
    #5 arst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
